// File: rtl/lifo_arbiter.sv
// lifo_arbiter: round-robin arbiter giving two requesters shared access to an
// external LIFO stack.
// Each transaction runs IDLE -> ISSUE -> CAPTURE -> ACK.
// Occupancy is tracked locally in count. Accept/reject decisions never look
// at the stack's own flags.
//
// Ports
//   clk, Rst          clock; synchronous active-high reset
//   reqN, rwN, dinN   requester N: request (held until ackN), op (0 push /
//                     1 pop), push data
//   ackN, errN        one-cycle completion pulse; errN flags a rejected op
//   doutN             data popped for requester N (held otherwise)
//   stk_en/rw/rst/din stack control; stk_en+stk_rst are forced high in reset
//   stk_dout          stack read data, valid the cycle after an enabled pop
//   count, full, empty
//                     stack occupancy and decoded flags
module lifo_arbiter #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             rw0,
    input  logic             rw1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic             stk_en,
    output logic             stk_rw,
    output logic             stk_rst,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout,
    output logic [2:0]       count,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    localparam logic [2:0] CNT_MAX = 3'(DEPTH);

    state_t           state;
    logic             gnt;     // requester owning the in-flight op
    logic             last;    // requester granted most recently
    logic             rw_q;
    logic [WIDTH-1:0] din_q;
    logic             rej_q;
    logic             accept;
    logic             pick;

    // With both requesting, the one not granted last wins. last resets to 1,
    // so req0 is favoured first.
    assign pick   = (req0 && req1) ? ~last : req1;
    assign accept = rw_q ? (count != 3'd0) : (count != CNT_MAX);

    assign full    = (count == CNT_MAX);
    assign empty   = (count == 3'd0);
    assign stk_rst = Rst;
    assign stk_en  = Rst | ((state == ISSUE) && accept);
    assign stk_rw  = Rst ? 1'b0 : rw_q;
    assign stk_din = Rst ? '0 : din_q;

    always_ff @(posedge clk) begin
        if (Rst) begin
            state <= IDLE;
            count <= 3'd0;
            last  <= 1'b1;
            gnt   <= 1'b0;
            rw_q  <= 1'b0;
            din_q <= '0;
            rej_q <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            dout0 <= '0;
            dout1 <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt   <= pick;
                        last  <= pick;
                        rw_q  <= pick ? rw1 : rw0;
                        din_q <= pick ? din1 : din0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    rej_q <= ~accept;
                    if (accept) count <= rw_q ? count - 3'd1 : count + 3'd1;
                    state <= CAPTURE;
                end
                // Rejected ops also pass through CAPTURE, but do nothing
                // there. This keeps the ack latency the same for every op.
                CAPTURE: begin
                    if (!rej_q && rw_q) begin
                        if (gnt) dout1 <= stk_dout;
                        else     dout0 <= stk_dout;
                    end
                    ack0  <= ~gnt;
                    ack1  <= gnt;
                    err0  <= ~gnt & rej_q;
                    err1  <= gnt & rej_q;
                    state <= ACK;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
